// File: rtl/risc0_host_loader.sv
// Framed byte-stream command decoder driving the risc0 host bus: word writes ('W'),
// word reads ('R'), execution start ('G') and sticky status query ('S').
module risc0_host_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] host_addr,
  output logic [31:0] host_wdata,
  input  logic [31:0] host_rdata,
  output logic        host_we,
  output logic        host_re,
  input  logic        host_ready,
  output logic        start_execution,
  input  logic        execution_done,
  input  logic        execution_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, OP_G = 8'h47, OP_S = 8'h53;

  typedef enum logic [2:0] {IDLE, HDR, DATA, BUS_WR, BUS_RD, RESP} state_t;
  state_t state, state_nx;

  logic [7:0]    opcode;
  logic [2:0]    hdr_cnt;
  logic [1:0]    byte_cnt;
  logic [15:0]   words_left;
  logic [TW-1:0] tmo_cnt;
  logic          done_sticky, err_sticky;
  logic [23:0]   resp_buf;
  logic [1:0]    resp_left;
  logic          rx_fire, tmo_hit, resp_load, resp_four, sticky_clr;
  logic [31:0]   resp_word;

  assign rx_fire = rx_valid & rx_ready;
  assign tmo_hit = !rx_fire && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // Every path into RESP goes through resp_load so the first byte is staged uniformly.
  always_comb begin
    state_nx   = state;
    resp_load  = 1'b0;
    resp_four  = 1'b0;
    resp_word  = {24'h0, NAK_BYTE};
    sticky_clr = 1'b0;
    case (state)
      IDLE: if (rx_fire) begin
        case (rx_data)
          OP_W, OP_R: state_nx = HDR;
          OP_G: begin
            sticky_clr = 1'b1;
            resp_load  = 1'b1;
            resp_word  = {24'h0, ACK_BYTE};
          end
          OP_S: begin
            resp_load = 1'b1;
            resp_word = {30'h0, err_sticky, done_sticky};
          end
          default: resp_load = 1'b1;
        endcase
      end
      HDR: if (rx_fire) begin
        if (opcode == OP_R && hdr_cnt == 3'd3) begin
          if (host_addr[1:0] != 2'b00) resp_load = 1'b1;
          else                         state_nx  = BUS_RD;
        end else if (hdr_cnt == 3'd5) begin
          if (host_addr[1:0] != 2'b00) resp_load = 1'b1;
          else if ({rx_data, words_left[7:0]} == 16'h0) begin
            resp_load = 1'b1;
            resp_word = {24'h0, ACK_BYTE};
          end else state_nx = DATA;
        end
      end else if (tmo_hit) resp_load = 1'b1;
      DATA: if (rx_fire) begin
        if (byte_cnt == 2'd3) state_nx = BUS_WR;
      end else if (tmo_hit) resp_load = 1'b1;
      BUS_WR: if (host_ready) begin
        if (words_left == 16'd1) begin
          resp_load = 1'b1;
          resp_word = {24'h0, ACK_BYTE};
        end else state_nx = DATA;
      end
      BUS_RD: if (host_ready) begin
        resp_load = 1'b1;
        resp_four = 1'b1;
        resp_word = host_rdata;
      end
      RESP: if (tx_valid && tx_ready && resp_left == 2'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (resp_load) state_nx = RESP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready        <= 1'b0;
      tx_valid        <= 1'b0;
      tx_data         <= 8'h0;
      host_we         <= 1'b0;
      host_re         <= 1'b0;
      host_addr       <= 32'h0;
      host_wdata      <= 32'h0;
      start_execution <= 1'b0;
      done_sticky     <= 1'b0;
      err_sticky      <= 1'b0;
      tmo_cnt         <= '0;
      opcode          <= 8'h0;
      hdr_cnt         <= 3'd0;
      byte_cnt        <= 2'd0;
      words_left      <= 16'h0;
      resp_buf        <= 24'h0;
      resp_left       <= 2'd0;
    end else begin
      rx_ready        <= state_nx inside {IDLE, HDR, DATA};
      host_we         <= (state_nx == BUS_WR);
      host_re         <= (state_nx == BUS_RD);
      start_execution <= sticky_clr;
      // Clear wins over a coincident level; the flag re-arms on the following cycle.
      done_sticky     <= !sticky_clr && (done_sticky || execution_done);
      err_sticky      <= !sticky_clr && (err_sticky || execution_error);
      tmo_cnt         <= ((state == HDR || state == DATA) && !rx_fire) ? tmo_cnt + 1'b1 : '0;

      if (rx_fire) begin
        case (state)
          IDLE: begin
            opcode   <= rx_data;
            hdr_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
          end
          HDR: begin
            hdr_cnt <= hdr_cnt + 3'd1;
            if (!hdr_cnt[2])     host_addr[{hdr_cnt[1:0], 3'b000} +: 8] <= rx_data;
            else if (!hdr_cnt[0]) words_left[7:0]  <= rx_data;
            else                  words_left[15:8] <= rx_data;
          end
          DATA: begin
            host_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
          default: ;
        endcase
      end

      if (state == BUS_WR && host_ready) begin
        host_addr  <= host_addr + 32'd4;
        words_left <= words_left - 16'd1;
      end

      if (resp_load) begin
        tx_valid  <= 1'b1;
        tx_data   <= resp_word[7:0];
        resp_buf  <= resp_word[31:8];
        resp_left <= resp_four ? 2'd3 : 2'd0;
      end else if (tx_valid && tx_ready) begin
        if (resp_left == 2'd0) tx_valid <= 1'b0;
        else begin
          tx_data   <= resp_buf[7:0];
          resp_buf  <= {8'h0, resp_buf[23:8]};
          resp_left <= resp_left - 2'd1;
        end
      end
    end
  end
endmodule
